// File: rtl/conv_tile_scheduler_if.sv
// Scheduler bundle: command, input-memory read, engine and output-memory
// write signals. master = scheduler side, slave = environment side.
interface conv_tile_scheduler_if #(
  parameter int ADDR_W = 9
);
  logic                     cmd_start;
  logic                     cmd_abort;
  logic                     cmd_busy;
  logic                     cmd_done;
  logic                     cmd_err;
  logic                     in_rd_en;
  logic [ADDR_W-1:0]        in_rd_addr;
  logic signed [7:0]        in_rd_data;
  logic [0:5][0:5][7:0]     tile_out;
  logic                     eng_rst_n;
  logic                     conv_start;
  logic                     conv_done;
  logic [0:3][0:3][15:0]    conv_c;
  logic                     out_wr_en;
  logic [ADDR_W-1:0]        out_wr_addr;
  logic signed [15:0]       out_wr_data;

  modport master (
    input  cmd_start, cmd_abort,
    input  in_rd_data, conv_done, conv_c,
    output cmd_busy, cmd_done, cmd_err,
    output in_rd_en, in_rd_addr, tile_out,
    output eng_rst_n, conv_start,
    output out_wr_en, out_wr_addr, out_wr_data
  );

  modport slave (
    output cmd_start, cmd_abort,
    output in_rd_data, conv_done, conv_c,
    input  cmd_busy, cmd_done, cmd_err,
    input  in_rd_en, in_rd_addr, tile_out,
    input  eng_rst_n, conv_start,
    input  out_wr_en, out_wr_addr, out_wr_data
  );
endinterface

// File: rtl/conv_tile_scheduler.sv
// Walks 4x4 output tiles: reads a 6x6 input window, runs the engine,
// writes 16 results. Ports: clk, rst (async, high), bus (master).
module conv_tile_scheduler #(
  parameter int IMG_W   = 18,
  parameter int IMG_H   = 18,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 1023
) (
  input logic                   clk,
  input logic                   rst,
  conv_tile_scheduler_if.master bus
);
  localparam int OUT_W = IMG_W - 2;
  localparam int OUT_H = IMG_H - 2;
  localparam int NTX   = OUT_W / 4;
  localparam int NTY   = OUT_H / 4;
  localparam int TXW   = $clog2(NTX + 1);
  localparam int TYW   = $clog2(NTY + 1);

  typedef enum logic [2:0] {
    IDLE, ENG_RST, LOAD, WAIT, STORE, NEXT
  } state_t;

  state_t         state;
  logic [TXW-1:0] tx;
  logic [TYW-1:0] ty;
  logic [2:0]     rr, rc;
  logic [2:0]     cr, cc;
  logic [5:0]     lcnt;
  logic [1:0]     sr, sc;
  logic [9:0]     wd;

  logic [2:0] nrr, nrc;
  logic [1:0] nsr, nsc;
  logic       last_tx, last_ty;

  function automatic logic [ADDR_W-1:0] in_addr(
    input int y, input int x, input int r, input int c
  );
    return ADDR_W'((4 * y + r) * IMG_W + 4 * x + c);
  endfunction

  function automatic logic [ADDR_W-1:0] out_addr(
    input int y, input int x, input int r, input int c
  );
    return ADDR_W'((4 * y + r) * OUT_W + 4 * x + c);
  endfunction

  always_comb begin
    nrc     = (rc == 3'd5) ? 3'd0 : rc + 3'd1;
    nrr     = (rc == 3'd5) ? rr + 3'd1 : rr;
    nsc     = sc + 2'd1;
    nsr     = (sc == 2'd3) ? sr + 2'd1 : sr;
    last_tx = (tx == TXW'(NTX - 1));
    last_ty = (ty == TYW'(NTY - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      tx              <= '0;
      ty              <= '0;
      rr              <= '0;
      rc              <= '0;
      cr              <= '0;
      cc              <= '0;
      lcnt            <= '0;
      sr              <= '0;
      sc              <= '0;
      wd              <= '0;
      bus.cmd_busy    <= 1'b0;
      bus.cmd_done    <= 1'b0;
      bus.cmd_err     <= 1'b0;
      bus.in_rd_en    <= 1'b0;
      bus.in_rd_addr  <= '0;
      bus.tile_out    <= '0;
      bus.eng_rst_n   <= 1'b0;
      bus.conv_start  <= 1'b0;
      bus.out_wr_en   <= 1'b0;
      bus.out_wr_addr <= '0;
      bus.out_wr_data <= '0;
    end else if (bus.cmd_abort) begin
      state          <= IDLE;
      bus.cmd_busy   <= 1'b0;
      bus.cmd_done   <= 1'b0;
      bus.in_rd_en   <= 1'b0;
      bus.out_wr_en  <= 1'b0;
      bus.conv_start <= 1'b0;
      bus.eng_rst_n  <= 1'b0;
    end else begin
      bus.cmd_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cmd_start) begin
            state        <= ENG_RST;
            bus.cmd_busy <= 1'b1;
            bus.cmd_err  <= 1'b0;
            tx           <= '0;
            ty           <= '0;
          end
        end
        ENG_RST: begin
          state          <= LOAD;
          bus.eng_rst_n  <= 1'b1;
          bus.in_rd_en   <= 1'b1;
          bus.in_rd_addr <= in_addr(int'(ty), int'(tx), 0, 0);
          rr             <= '0;
          rc             <= '0;
          lcnt           <= '0;
        end
        LOAD: begin
          // data for the read issued last cycle lands now
          lcnt <= lcnt + 6'd1;
          cr   <= rr;
          cc   <= rc;
          if (lcnt != 6'd0)
            bus.tile_out[cr][cc] <= bus.in_rd_data;
          if (lcnt < 6'd35) begin
            rr             <= nrr;
            rc             <= nrc;
            bus.in_rd_addr <= in_addr(int'(ty), int'(tx),
                                      int'(nrr), int'(nrc));
          end else begin
            bus.in_rd_en <= 1'b0;
          end
          if (lcnt == 6'd36) begin
            state          <= WAIT;
            bus.conv_start <= 1'b1;
            wd             <= '0;
          end
        end
        WAIT: begin
          if (bus.conv_done) begin
            state           <= STORE;
            bus.conv_start  <= 1'b0;
            bus.out_wr_en   <= 1'b1;
            sr              <= '0;
            sc              <= '0;
            bus.out_wr_addr <= out_addr(int'(ty), int'(tx), 0, 0);
            bus.out_wr_data <= bus.conv_c[0][0];
          end else if (wd == 10'(TIMEOUT - 1)) begin
            state          <= IDLE;
            bus.conv_start <= 1'b0;
            bus.cmd_err    <= 1'b1;
            bus.cmd_done   <= 1'b1;
            bus.cmd_busy   <= 1'b0;
            bus.eng_rst_n  <= 1'b0;
          end else begin
            wd <= wd + 10'd1;
          end
        end
        STORE: begin
          if (sr == 2'd3 && sc == 2'd3) begin
            state         <= NEXT;
            bus.out_wr_en <= 1'b0;
          end else begin
            sr              <= nsr;
            sc              <= nsc;
            bus.out_wr_addr <= out_addr(int'(ty), int'(tx),
                                        int'(nsr), int'(nsc));
            bus.out_wr_data <= bus.conv_c[nsr][nsc];
          end
        end
        NEXT: begin
          bus.eng_rst_n <= 1'b0;
          if (last_tx && last_ty) begin
            state        <= IDLE;
            bus.cmd_done <= 1'b1;
            bus.cmd_busy <= 1'b0;
          end else begin
            state <= ENG_RST;
            if (last_tx) begin
              tx <= '0;
              ty <= ty + TYW'(1);
            end else begin
              tx <= tx + TXW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Bench for conv_tile_scheduler: memory and engine models, an image-level
// reference of the convolution, and directed job scenarios.
module tb_conv_tile_scheduler;
  localparam int IMG_W  = 18;
  localparam int IMG_H  = 18;
  localparam int ADDR_W = 9;
  localparam int OUT_W  = IMG_W - 2;
  localparam int OUT_H  = IMG_H - 2;
  localparam int NTX    = OUT_W / 4;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NOUT   = OUT_W * OUT_H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_tile_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  conv_tile_scheduler #(
    .IMG_W(IMG_W), .IMG_H(IMG_H),
    .ADDR_W(ADDR_W), .TIMEOUT(1023)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  logic signed [7:0] img [NPIX];
  int kern [3][3];
  int exp_out [NOUT];

  task automatic build_model();
    for (int y = 0; y < OUT_H; y++)
      for (int x = 0; x < OUT_W; x++) begin
        int s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s += int'(img[(y + i) * IMG_W + x + j]) * kern[i][j];
        exp_out[y * OUT_W + x] = s;
      end
  endtask

  // synchronous input memory: one cycle read latency
  always @(posedge clk)
    if (bus.in_rd_en) bus.in_rd_data <= img[bus.in_rd_addr];

  int  eng_dly = 3;
  bit  eng_hang = 1'b0;
  int  ecnt;

  function automatic int conv_at(input int r, input int c);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += int'($signed(bus.tile_out[r + i][c + j])) * kern[i][j];
    return s;
  endfunction

  // engine: done is sticky until eng_rst_n drops
  always @(posedge clk) begin
    if (!bus.eng_rst_n) begin
      bus.conv_done <= 1'b0;
      ecnt          <= 0;
    end else if (bus.conv_start && !bus.conv_done && !eng_hang) begin
      if (ecnt == eng_dly - 1) begin
        bus.conv_done <= 1'b1;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            bus.conv_c[r][c] <= 16'(conv_at(r, c));
      end else begin
        ecnt <= ecnt + 1;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rd_idx, wr_idx, done_cnt, cs_cnt;
  int wr_cnt [NOUT];
  int out_mem [NOUT];
  int cyc_start, cyc_done;

  always @(negedge clk) begin : mon
    int t, p, ea, a;
    if (!rst) begin
      if (bus.in_rd_en) begin
        t  = rd_idx / 36;
        p  = rd_idx % 36;
        ea = (4 * (t / NTX) + p / 6) * IMG_W + 4 * (t % NTX) + p % 6;
        chk("rd_addr", bus.in_rd_addr, ea);
        rd_idx++;
      end
      if (bus.out_wr_en) begin
        t  = wr_idx / 16;
        p  = wr_idx % 16;
        ea = (4 * (t / NTX) + p / 4) * OUT_W + 4 * (t % NTX) + p % 4;
        a  = int'(bus.out_wr_addr);
        chk("wr_addr", a, ea);
        if (a < NOUT) begin
          chk("wr_data", $signed(bus.out_wr_data), exp_out[a]);
          out_mem[a] = int'($signed(bus.out_wr_data));
          wr_cnt[a]++;
        end
        wr_idx++;
      end
      if (bus.cmd_done) done_cnt++;
      if (bus.conv_start) cs_cnt++;
    end
  end

  task automatic clear_job();
    rd_idx = 0;
    wr_idx = 0;
    done_cnt = 0;
    cs_cnt = 0;
    foreach (wr_cnt[i]) begin
      wr_cnt[i] = 0;
      out_mem[i] = -999;
    end
  endtask

  task automatic start_job();
    clear_job();
    bus.cmd_start = 1'b1;
    @(posedge clk);
    #1;
    cyc_start = cyc;
    bus.cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string nm);
    int n = 0;
    while (bus.cmd_done !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(nm, bus.cmd_done, 1);
    cyc_done = cyc;
  endtask

  task automatic finish_full(input string p, input int lat);
    int ones = 0;
    wait_done(3000, {p, "_done"});
    chk({p, "_lat"}, cyc_done - cyc_start, lat);
    @(negedge clk);
    chk({p, "_pulse"}, bus.cmd_done, 0);
    chk({p, "_busy"}, bus.cmd_busy, 0);
    chk({p, "_err"}, bus.cmd_err, 0);
    chk({p, "_erst"}, bus.eng_rst_n, 0);
    chk({p, "_wr"}, wr_idx, 256);
    chk({p, "_rd"}, rd_idx, 576);
    foreach (wr_cnt[i]) if (wr_cnt[i] == 1) ones++;
    chk({p, "_once"}, ones, NOUT);
    chk({p, "_ndone"}, done_cnt, 1);
  endtask

  task automatic wait_sig(input int maxc, input string nm,
                          input bit is_cs);
    int n = 0;
    while (n < maxc && !(is_cs ? bus.conv_start : bus.in_rd_en)) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n < maxc, 1);
  endtask

  initial begin : wdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int w;
    bus.cmd_start = 1'b0;
    bus.cmd_abort = 1'b0;
    clear_job();
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.cmd_busy, 0);
    chk("rst_done", bus.cmd_done, 0);
    chk("rst_err", bus.cmd_err, 0);
    chk("rst_rd_en", bus.in_rd_en, 0);
    chk("rst_wr_en", bus.out_wr_en, 0);
    chk("rst_cstart", bus.conv_start, 0);
    chk("rst_erst", bus.eng_rst_n, 0);
    chk("rst_raddr", bus.in_rd_addr, 0);
    chk("rst_waddr", bus.out_wr_addr, 0);
    chk("rst_wdata", bus.out_wr_data, 0);
    chk("rst_tile", |bus.tile_out, 0);
    rst = 1'b0;
    @(negedge clk);

    // all-ones image, all-ones kernel
    foreach (img[i]) img[i] = 8'sd1;
    foreach (kern[i, j]) kern[i][j] = 1;
    build_model();
    chk("model_a0", exp_out[0], 9);
    chk("model_a255", exp_out[255], 9);
    start_job();
    @(negedge clk);
    chk("a_busy_on", bus.cmd_busy, 1);
    chk("a_erst_low", bus.eng_rst_n, 0);
    finish_full("a", 944);
    chk("a_out0", out_mem[0], 9);
    chk("a_out255", out_mem[255], 9);

    // column ramp, centre-tap kernel
    foreach (img[i]) img[i] = 8'(i % IMG_W);
    foreach (kern[i, j]) kern[i][j] = (i == 1 && j == 1) ? 1 : 0;
    build_model();
    chk("model_b55", exp_out[16 * 3 + 7], 8);
    @(negedge clk);
    start_job();
    finish_full("b", 944);
    chk("b_out0", out_mem[0], 1);
    chk("b_out15", out_mem[15], 16);
    chk("b_out37", out_mem[37], 6);
    chk("b_out255", out_mem[255], 16);

    // engine never finishes
    eng_hang = 1'b1;
    @(negedge clk);
    start_job();
    wait_done(1500, "c_done");
    chk("c_lat", cyc_done - cyc_start, 1061);
    chk("c_err", bus.cmd_err, 1);
    chk("c_busy", bus.cmd_busy, 0);
    chk("c_erst", bus.eng_rst_n, 0);
    chk("c_wait_cyc", cs_cnt, 1023);
    chk("c_wr", wr_idx, 0);
    chk("c_rd", rd_idx, 36);
    @(negedge clk);
    chk("c_pulse", bus.cmd_done, 0);
    chk("c_err_hold", bus.cmd_err, 1);
    eng_hang = 1'b0;

    // abort on LOAD cycle 10
    start_job();
    chk("d_err_clr", bus.cmd_err, 0);
    wait_sig(10, "d_load", 1'b0);
    repeat (10) @(negedge clk);
    bus.cmd_abort = 1'b1;
    @(negedge clk);
    bus.cmd_abort = 1'b0;
    chk("d_rd_en", bus.in_rd_en, 0);
    chk("d_busy", bus.cmd_busy, 0);
    chk("d_rd", rd_idx, 11);
    repeat (20) @(negedge clk);
    chk("d_nodone", done_cnt, 0);
    chk("d_idle_rd", rd_idx, 11);
    start_job();
    finish_full("d2", 944);

    // start re-pulsed during WAIT
    @(negedge clk);
    start_job();
    wait_sig(200, "e_wait", 1'b1);
    bus.cmd_start = 1'b1;
    @(negedge clk);
    bus.cmd_start = 1'b0;
    finish_full("e", 944);
    repeat (5) @(negedge clk);
    chk("e_idle", bus.cmd_busy, 0);
    chk("e_ndone", done_cnt, 1);

    // reset during STORE of tile 5
    start_job();
    w = 0;
    while (wr_idx < 83 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("f_in_store", bus.out_wr_en, 1);
    rst = 1'b1;
    #1;
    chk("f_busy", bus.cmd_busy, 0);
    chk("f_wr_en", bus.out_wr_en, 0);
    chk("f_rd_en", bus.in_rd_en, 0);
    chk("f_cstart", bus.conv_start, 0);
    chk("f_erst", bus.eng_rst_n, 0);
    chk("f_waddr", bus.out_wr_addr, 0);
    chk("f_wdata", bus.out_wr_data, 0);
    chk("f_tile", |bus.tile_out, 0);
    chk("f_done", bus.cmd_done, 0);
    @(negedge clk);
    rst = 1'b0;
    w = wr_idx;
    done_cnt = 0;
    repeat (100) @(negedge clk);
    chk("f_nowr", wr_idx, w);
    chk("f_nodone", done_cnt, 0);
    chk("f_idle", bus.cmd_busy, 0);
    start_job();
    finish_full("g", 944);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
